// File: rtl/gng_pkg.sv
// gng_pkg: constants and types shared by the Gaussian noise generator's
// inverse-CDF path (LZD, segment translator, coefficient ROM).
//   LZ_W    : width of the leading-zero-count field
//   SEG_W   : width of a segment index ({lz, sb})
//   MAX_LZ  : largest leading-zero count that owns its own octave
//   SEG_SAT : last segment; every deeper tail code lands here
package gng_pkg;
   localparam int LZ_W   = 6;
   localparam int SEG_W  = LZ_W + 1;
   localparam int MAX_LZ = 61;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_SAT = seg_t'(2 * MAX_LZ + 1);
endpackage

// File: rtl/rom_trans_seg_if.sv
// rom_trans_seg_if: LZD-to-translator bus.
//   LZDout  : [6:1] leading-zero count, [0] bit after the leading one
//   segment : registered coefficient-ROM segment index
// master = upstream LZD side, slave = the translator.
interface rom_trans_seg_if;
   import gng_pkg::*;

   seg_t LZDout;
   seg_t segment;

   modport master (output LZDout, input  segment);
   modport slave  (input  LZDout, output segment);
endinterface

// File: rtl/rom_trans_seg.sv
// rom_trans_seg: maps the LZD result of the uniform word to the segment
// index of the polynomial-coefficient ROM. One octave per leading-zero
// count, halved by the bit after the leading one; counts past MAX_LZ
// saturate to SEG_SAT. One register stage, no handshake.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset, clears segment
//   bus.LZDout : {lz, sb} from the LZD
//   bus.segment: segment index, one cycle after LZDout is sampled
module rom_trans_seg
   import gng_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   rom_trans_seg_if.slave bus
);

   seg_t seg_next;

   // Explicit per-code table so the segmentation can be re-tuned entry by
   // entry without touching any arithmetic. Today codes up to 123 map to
   // themselves ({lz, sb}); lz = 62/63 collapse onto the last segment.
   always_comb begin
      seg_next = SEG_SAT;
      case (bus.LZDout)
         7'd0:   seg_next = 7'd0;   7'd1:   seg_next = 7'd1;   7'd2:   seg_next = 7'd2;   7'd3:   seg_next = 7'd3;
         7'd4:   seg_next = 7'd4;   7'd5:   seg_next = 7'd5;   7'd6:   seg_next = 7'd6;   7'd7:   seg_next = 7'd7;
         7'd8:   seg_next = 7'd8;   7'd9:   seg_next = 7'd9;   7'd10:  seg_next = 7'd10;  7'd11:  seg_next = 7'd11;
         7'd12:  seg_next = 7'd12;  7'd13:  seg_next = 7'd13;  7'd14:  seg_next = 7'd14;  7'd15:  seg_next = 7'd15;
         7'd16:  seg_next = 7'd16;  7'd17:  seg_next = 7'd17;  7'd18:  seg_next = 7'd18;  7'd19:  seg_next = 7'd19;
         7'd20:  seg_next = 7'd20;  7'd21:  seg_next = 7'd21;  7'd22:  seg_next = 7'd22;  7'd23:  seg_next = 7'd23;
         7'd24:  seg_next = 7'd24;  7'd25:  seg_next = 7'd25;  7'd26:  seg_next = 7'd26;  7'd27:  seg_next = 7'd27;
         7'd28:  seg_next = 7'd28;  7'd29:  seg_next = 7'd29;  7'd30:  seg_next = 7'd30;  7'd31:  seg_next = 7'd31;
         7'd32:  seg_next = 7'd32;  7'd33:  seg_next = 7'd33;  7'd34:  seg_next = 7'd34;  7'd35:  seg_next = 7'd35;
         7'd36:  seg_next = 7'd36;  7'd37:  seg_next = 7'd37;  7'd38:  seg_next = 7'd38;  7'd39:  seg_next = 7'd39;
         7'd40:  seg_next = 7'd40;  7'd41:  seg_next = 7'd41;  7'd42:  seg_next = 7'd42;  7'd43:  seg_next = 7'd43;
         7'd44:  seg_next = 7'd44;  7'd45:  seg_next = 7'd45;  7'd46:  seg_next = 7'd46;  7'd47:  seg_next = 7'd47;
         7'd48:  seg_next = 7'd48;  7'd49:  seg_next = 7'd49;  7'd50:  seg_next = 7'd50;  7'd51:  seg_next = 7'd51;
         7'd52:  seg_next = 7'd52;  7'd53:  seg_next = 7'd53;  7'd54:  seg_next = 7'd54;  7'd55:  seg_next = 7'd55;
         7'd56:  seg_next = 7'd56;  7'd57:  seg_next = 7'd57;  7'd58:  seg_next = 7'd58;  7'd59:  seg_next = 7'd59;
         7'd60:  seg_next = 7'd60;  7'd61:  seg_next = 7'd61;  7'd62:  seg_next = 7'd62;  7'd63:  seg_next = 7'd63;
         7'd64:  seg_next = 7'd64;  7'd65:  seg_next = 7'd65;  7'd66:  seg_next = 7'd66;  7'd67:  seg_next = 7'd67;
         7'd68:  seg_next = 7'd68;  7'd69:  seg_next = 7'd69;  7'd70:  seg_next = 7'd70;  7'd71:  seg_next = 7'd71;
         7'd72:  seg_next = 7'd72;  7'd73:  seg_next = 7'd73;  7'd74:  seg_next = 7'd74;  7'd75:  seg_next = 7'd75;
         7'd76:  seg_next = 7'd76;  7'd77:  seg_next = 7'd77;  7'd78:  seg_next = 7'd78;  7'd79:  seg_next = 7'd79;
         7'd80:  seg_next = 7'd80;  7'd81:  seg_next = 7'd81;  7'd82:  seg_next = 7'd82;  7'd83:  seg_next = 7'd83;
         7'd84:  seg_next = 7'd84;  7'd85:  seg_next = 7'd85;  7'd86:  seg_next = 7'd86;  7'd87:  seg_next = 7'd87;
         7'd88:  seg_next = 7'd88;  7'd89:  seg_next = 7'd89;  7'd90:  seg_next = 7'd90;  7'd91:  seg_next = 7'd91;
         7'd92:  seg_next = 7'd92;  7'd93:  seg_next = 7'd93;  7'd94:  seg_next = 7'd94;  7'd95:  seg_next = 7'd95;
         7'd96:  seg_next = 7'd96;  7'd97:  seg_next = 7'd97;  7'd98:  seg_next = 7'd98;  7'd99:  seg_next = 7'd99;
         7'd100: seg_next = 7'd100; 7'd101: seg_next = 7'd101; 7'd102: seg_next = 7'd102; 7'd103: seg_next = 7'd103;
         7'd104: seg_next = 7'd104; 7'd105: seg_next = 7'd105; 7'd106: seg_next = 7'd106; 7'd107: seg_next = 7'd107;
         7'd108: seg_next = 7'd108; 7'd109: seg_next = 7'd109; 7'd110: seg_next = 7'd110; 7'd111: seg_next = 7'd111;
         7'd112: seg_next = 7'd112; 7'd113: seg_next = 7'd113; 7'd114: seg_next = 7'd114; 7'd115: seg_next = 7'd115;
         7'd116: seg_next = 7'd116; 7'd117: seg_next = 7'd117; 7'd118: seg_next = 7'd118; 7'd119: seg_next = 7'd119;
         7'd120: seg_next = 7'd120; 7'd121: seg_next = 7'd121; 7'd122: seg_next = 7'd122; 7'd123: seg_next = 7'd123;
         // lz = 62, 63: deep tail shares the last segment, sb ignored
         7'd124: seg_next = SEG_SAT; 7'd125: seg_next = SEG_SAT; 7'd126: seg_next = SEG_SAT; 7'd127: seg_next = SEG_SAT;
         default: seg_next = SEG_SAT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) bus.segment <= '0;
      else      bus.segment <= seg_next;
   end

endmodule

// File: tb/tb_rom_trans_seg.sv
module tb_rom_trans_seg;
   logic clk;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [6:0] sb_q[$];

   rom_trans_seg_if bus ();

   rom_trans_seg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timed out, got no summary, required finish");
      $fatal(1, "watchdog");
   end

   // reference mapping straight from the segmentation rule
   function automatic logic [6:0] exp_seg(input logic [6:0] code);
      logic [5:0] lz;
      lz = code[6:1];
      if (lz > 6'd61) return 7'd123;
      return {lz, code[0]};
   endfunction

   // drive at negedge, DUT captures at posedge, compare at following negedge
   task automatic step(input logic [6:0] v, input string nm);
      logic [6:0] e;
      @(negedge clk);
      bus.LZDout = v;
      sb_q.push_back(exp_seg(v));
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.segment !== e) begin
         n_err++;
         $display("FAIL %s: in=%0d got=%0d exp=%0d", nm, v, bus.segment, e);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.LZDout = 7'h55;
      #1 rst = 1'b0;
      #1;
      n_cmp++;
      if (bus.segment !== 7'd0) begin
         n_err++; $display("FAIL reset_async: got=%0d exp=0", bus.segment);
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.segment !== 7'd0) begin
         n_err++; $display("FAIL reset_hold: got=%0d exp=0", bus.segment);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.LZDout = {6'd2, 1'b1};
      sb_q.delete();
      sb_q.push_back(exp_seg(bus.LZDout));
      #1;
      n_cmp++;
      if (bus.segment !== 7'd0) begin
         n_err++; $display("FAIL reset_release_pre_edge: got=%0d exp=0", bus.segment);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.segment !== sb_q[0]) begin
         n_err++; $display("FAIL reset_first_capture: got=%0d exp=%0d", bus.segment, sb_q[0]);
      end
      void'(sb_q.pop_front());
   endtask

   task automatic test_sweep();
      for (int lz = 0; lz < 6; lz++)
         for (int sb = 0; sb < 2; sb++)
            repeat (2) step({lz[5:0], sb[0]}, "sweep");
   endtask

   task automatic test_boundary();
      step({6'd61, 1'b0}, "boundary_61_0");
      step({6'd61, 1'b1}, "boundary_61_1");
      step({6'd60, 1'b1}, "boundary_60_1");
   endtask

   task automatic test_saturation();
      step({6'd62, 1'b0}, "sat_62_0");
      step({6'd62, 1'b1}, "sat_62_1");
      step({6'd63, 1'b0}, "sat_63_0");
      step({6'd63, 1'b1}, "sat_63_1");
   endtask

   task automatic test_latency();
      logic [6:0] e;
      logic [6:0] mid;
      @(negedge clk);
      bus.LZDout = {6'd0, 1'b0};
      sb_q.push_back(exp_seg(bus.LZDout));
      @(posedge clk);
      // change input right after the capturing edge: output must not follow
      #1 bus.LZDout = {6'd5, 1'b1};
      sb_q.push_back(exp_seg(bus.LZDout));
      #2 mid = bus.segment;
      e = sb_q.pop_front();
      n_cmp++;
      if (mid !== e) begin
         n_err++; $display("FAIL latency_first: got=%0d exp=%0d", mid, e);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.segment !== e) begin
         n_err++; $display("FAIL latency_no_glitch: got=%0d exp=%0d", bus.segment, e);
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (bus.segment !== e) begin
         n_err++; $display("FAIL latency_second: got=%0d exp=%0d", bus.segment, e);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] v;
      logic [6:0] e;
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         v = 7'($urandom_range(0, 127));
         if (i == 0) v = 7'd127;
         bus.LZDout = v;
         sb_q.push_back(exp_seg(v));
         // mid-cycle junk before the edge that must be ignored
         @(posedge clk);
         #2 bus.LZDout = ~v;
         @(negedge clk);
         e = sb_q.pop_front();
         n_cmp++;
         if (bus.segment !== e) begin
            n_err++; $display("FAIL b2b[%0d]: in=%0d got=%0d exp=%0d", i, v, bus.segment, e);
         end
      end
   endtask

   task automatic test_reset_mid();
      step({6'd5, 1'b1}, "pre_mid_reset");
      @(posedge clk);
      #2 rst = 1'b0;
      sb_q.delete();
      #1;
      n_cmp++;
      if (bus.segment !== 7'd0) begin
         n_err++; $display("FAIL midreset_async: got=%0d exp=0", bus.segment);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.segment !== 7'd0) begin
         n_err++; $display("FAIL midreset_hold: got=%0d exp=0", bus.segment);
      end
      @(negedge clk);
      rst = 1'b1;
      sb_q.push_back(exp_seg(bus.LZDout));
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.segment !== sb_q[0]) begin
         n_err++; $display("FAIL midreset_recover: got=%0d exp=%0d", bus.segment, sb_q[0]);
      end
      void'(sb_q.pop_front());
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_boundary();
      test_saturation();
      test_latency();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/rom_trans_seg.md
Name: rom_trans_seg

Overview:
- Segment-address translator in the Gaussian noise generator's inverse-CDF path.
- Converts the leading-zero-detector result of the uniform random word into the segment index used to address the polynomial-coefficient ROM.
- Non-uniform segmentation: one octave per leading-zero count, split into two half-octave sub-segments by the bit following the leading one.
- Output is registered, with a single pipeline stage between the LZD and the coefficient ROM.

Parameters:
- LZ_W, 6: width of the leading-zero-count field.
- SEG_W, 7: width of the segment index (LZ_W+1).
- MAX_LZ, 61: largest leading-zero count with its own octave; larger counts saturate to the last segment.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- LZDout  input  7  [6:1] = leading-zero count lz (0..63); [0] = sub-segment bit sb (bit after the leading one).
- segment  output  7  registered segment index for the coefficient ROM.

Behaviour:
- Reset:
  - rst low immediately forces segment to 0, independent of clk.
  - Output holds 0 while rst is low.
  - First capture is on the first rising edge after rst returns high.
- Translation, computed combinationally from LZDout:
  - lz <= MAX_LZ: seg_next = 2*lz + sb, i.e. {lz, sb}.
  - lz > MAX_LZ (62, 63): seg_next = 2*MAX_LZ + 1 = 123, regardless of sb (tail saturation).
  - Codes 124..127 are never produced.
- Implementation: a 128-entry case table (ROM) indexed by LZDout, giving one entry per input code. This keeps the mapping editable if the segmentation is re-tuned.
  - All 128 input codes are listed explicitly.
  - A default branch yields 123.
- Latency: exactly 1 clock cycle.
  - segment reflects the LZDout value sampled at the previous rising edge.
  - There is no combinational input-to-output path.
- No handshake:
  - A new input is accepted every cycle and the register updates every cycle.
  - A constant input produces a constant output.
- Input changing mid-cycle: only the value present at the rising edge matters.
- Reset asserted mid-stream: output goes to 0 at once. The pipeline value in flight is discarded, and there is no recovery of it.
- X/Z on LZDout after reset: output is undefined for that cycle only. The bench must not depend on it.
- Widths:
  - Arithmetic is unsigned.
  - 2*lz + sb never exceeds 7 bits, so no overflow handling beyond the saturation rule is needed.

Decomposition:
- Shared package (gng_pkg) holds:
  - Constants LZ_W = 6, SEG_W = 7, MAX_LZ = 61.
  - Constant SEG_SAT = 123.
  - A typedef for the segment index, shared with the coefficient ROM and the LZD.
- Single module, no sub-modules. The translation table and output register are too small to justify a split.

Test Plan:
- Reset: hold rst low for 2 cycles with LZDout arbitrary -> segment = 0 throughout. Release -> first update on the next edge.
- Sweep lz = 0..5, with sb = 0 then 1, each held 2 cycles, e.g. LZDout = {6'd2, 1'b1}:
  - Required segment sequence: 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, one cycle after each input.
  - For the example input, segment = 5 one cycle later.
- Boundary: lz = 61, sb = 0 -> 122; lz = 61, sb = 1 -> 123.
- Saturation: lz = 62 or 63 with sb = 0 or 1 -> 123.
- Latency: change LZDout from {0, 0} to {5, 1} on consecutive edges.
  - segment shows 0 on the edge after {0, 0} and 11 on the following edge.
  - No glitch between edges.
- Reset mid-operation: with segment = 11, drive rst low between clock edges -> segment = 0 immediately. Release -> next edge shows the mapped value of the current input.
